ttt_game_ctrl: RTL and testbench



---
 rtl/ttt_pkg.sv | 36 +++
 rtl/ttt_game_ctrl_if.sv | 55 +++++
 rtl/ttt_first_empty.sv | 28 ++
 rtl/ttt_game_ctrl.sv | 138 +++++++++++++
 tb/tb_ttt_game_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe game controller: cell codes, result codes,
// board layout and controller FSM states.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    WIN_P1 = 2'd1,
    WIN_P2 = 2'd2,
    DRAW   = 2'd3
  } result_t;

  // Indexed [row][col], both 1-based to match the keypad coordinates.
  typedef cell_t board_t [3:1][3:1];

  typedef enum logic [2:0] {
    StIdle,
    StTurn,
    StCheck,
    StEval,
    StOver
  } state_e;

  localparam logic [3:0] NumCells = 4'd9;

  // Row and column codes are 2 bits wide, so only 0 is out of range.
  function automatic logic coord_ok(logic [1:0] v);
    return v != 2'd0;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Signal bundle between the game controller, the input front end, the winner
// checker and the display/result logic.
interface ttt_game_ctrl_if #(
  parameter int unsigned TURN_TIMEOUT = 30,
  parameter int unsigned TO_W         = $clog2(TURN_TIMEOUT + 1)
);
  import ttt_pkg::*;

  logic            start;
  logic            move_valid;
  logic [1:0]      move_row;
  logic [1:0]      move_col;
  logic [1:0]      winner;
  board_t          board;
  logic            en_check;
  logic [1:0]      cur_player;
  logic            move_ack;
  logic            move_err;
  logic [TO_W-1:0] timeout_cnt;
  logic            game_over;
  logic [1:0]      result;

  modport master (
    output start,
    output move_valid,
    output move_row,
    output move_col,
    output winner,
    input  board,
    input  en_check,
    input  cur_player,
    input  move_ack,
    input  move_err,
    input  timeout_cnt,
    input  game_over,
    input  result
  );

  modport slave (
    input  start,
    input  move_valid,
    input  move_row,
    input  move_col,
    input  winner,
    output board,
    output en_check,
    output cur_player,
    output move_ack,
    output move_err,
    output timeout_cnt,
    output game_over,
    output result
  );

endinterface

// File: rtl/ttt_first_empty.sv
// Combinational priority encoder: first empty cell in row-major order
// (1,1)..(3,3), used as the auto-move target on turn timeout.
module ttt_first_empty
  import ttt_pkg::*;
(
  input  board_t     board_i,
  output logic [1:0] row_o,
  output logic [1:0] col_o,
  output logic       found_o
);

  // Scan backwards so the last hit is the lowest row-major position.
  always_comb begin
    row_o   = 2'd0;
    col_o   = 2'd0;
    found_o = 1'b0;
    for (int r = 3; r >= 1; r--) begin
      for (int c = 3; c >= 1; c--) begin
        if (board_i[r][c] == EMPTY) begin
          row_o   = 2'(r);
          col_o   = 2'(c);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the board, validates and commits moves,
// runs the per-turn timeout and sequences evaluation by the external checker.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 30,
  parameter int unsigned TO_W         = $clog2(TURN_TIMEOUT + 1)
) (
  input logic            clk,
  input logic            rst,
  ttt_game_ctrl_if.slave bus
);

  state_e          state_q, state_d;
  board_t          board_q, board_d;
  cell_t           cur_player_q, cur_player_d;
  result_t         result_q, result_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]      move_cnt_q, move_cnt_d;

  logic       ack, err;
  logic       in_range, cell_free, legal, expire;
  logic [1:0] row_idx, col_idx;
  logic [1:0] auto_row, auto_col;
  logic       auto_found;

  ttt_first_empty u_first_empty (
    .board_i (board_q),
    .row_o   (auto_row),
    .col_o   (auto_col),
    .found_o (auto_found)
  );

  // Clamp the lookup index so an out-of-range request never reads outside the board.
  assign in_range  = coord_ok(bus.move_row) && coord_ok(bus.move_col);
  assign row_idx   = in_range ? bus.move_row : 2'd1;
  assign col_idx   = in_range ? bus.move_col : 2'd1;
  assign cell_free = board_q[row_idx][col_idx] == EMPTY;
  assign legal     = (state_q == StTurn) && bus.move_valid && in_range && cell_free;
  assign expire    = (state_q == StTurn) && (tcnt_q == TO_W'(1)) && !legal && auto_found;

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    cur_player_d = cur_player_q;
    result_d     = result_q;
    tcnt_d       = tcnt_q;
    move_cnt_d   = move_cnt_q;
    ack          = 1'b0;
    err          = 1'b0;

    if (bus.start) begin
      state_d      = StTurn;
      cur_player_d = P1;
      result_d     = NONE;
      tcnt_d       = TO_W'(TURN_TIMEOUT);
      move_cnt_d   = 4'd0;
      for (int r = 1; r <= 3; r++) begin
        for (int c = 1; c <= 3; c++) begin
          board_d[r][c] = EMPTY;
        end
      end
    end else begin
      case (state_q)
        StIdle: ;
        StTurn: begin
          if (legal) begin
            board_d[bus.move_row][bus.move_col] = cur_player_q;
            ack        = 1'b1;
            move_cnt_d = move_cnt_q + 4'd1;
            tcnt_d     = '0;
            state_d    = StCheck;
          end else begin
            err = bus.move_valid;
            if (expire) begin
              board_d[auto_row][auto_col] = cur_player_q;
              ack        = 1'b1;
              move_cnt_d = move_cnt_q + 4'd1;
              tcnt_d     = '0;
              state_d    = StCheck;
            end else if (tcnt_q != '0) begin
              tcnt_d = tcnt_q - TO_W'(1);
            end
          end
        end
        StCheck: state_d = StEval;
        StEval: begin
          if ((bus.winner == 2'd1) || (bus.winner == 2'd2)) begin
            result_d = result_t'(bus.winner);
            state_d  = StOver;
          end else if ((bus.winner == 2'd3) || (move_cnt_q == NumCells)) begin
            // A full board is a draw even if the checker has not flagged it.
            result_d = DRAW;
            state_d  = StOver;
          end else begin
            cur_player_d = (cur_player_q == P1) ? P2 : P1;
            tcnt_d       = TO_W'(TURN_TIMEOUT);
            state_d      = StTurn;
          end
        end
        StOver: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_player_q <= EMPTY;
      result_q     <= NONE;
      tcnt_q       <= '0;
      move_cnt_q   <= 4'd0;
      for (int r = 1; r <= 3; r++) begin
        for (int c = 1; c <= 3; c++) begin
          board_q[r][c] <= EMPTY;
        end
      end
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      cur_player_q <= cur_player_d;
      result_q     <= result_d;
      tcnt_q       <= tcnt_d;
      move_cnt_q   <= move_cnt_d;
    end
  end

  assign bus.board       = board_q;
  assign bus.en_check    = (state_q == StCheck);
  assign bus.cur_player  = cur_player_q;
  assign bus.move_ack    = ack;
  assign bus.move_err    = err;
  assign bus.timeout_cnt = tcnt_q;
  assign bus.game_over   = (state_q == StOver);
  assign bus.result      = result_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl with a 4-cycle turn timeout;
// the bench plays the role of the winner checker.
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  localparam int unsigned TT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ttt_game_ctrl_if #(.TURN_TIMEOUT(TT)) bus ();

  ttt_game_ctrl #(.TURN_TIMEOUT(TT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [1:0] draw_r [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] draw_c [9] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3};
  logic [1:0] draw_b [9] = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a move for one cycle and report the same-cycle ack/err.
  task automatic drive_move(input logic [1:0] r, input logic [1:0] c,
                            output logic ack, output logic err);
    bus.move_valid = 1'b1;
    bus.move_row   = r;
    bus.move_col   = c;
    @(negedge clk);
    ack = bus.move_ack;
    err = bus.move_err;
    step();
    bus.move_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  function automatic bit board_empty();
    bit e = 1'b1;
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++)
        if (bus.board[r][c] !== EMPTY) e = 1'b0;
    return e;
  endfunction

  task automatic test_reset();
    logic a, e;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.cur_player !== 2'd0) begin
      errors++; $display("FAIL reset_cur_player got %0d want 0", bus.cur_player);
    end
    checks++;
    if ({bus.en_check, bus.game_over, bus.move_ack, bus.move_err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000",
                         {bus.en_check, bus.game_over, bus.move_ack, bus.move_err});
    end
    checks++;
    if (bus.result !== 2'd0 || bus.timeout_cnt !== '0) begin
      errors++; $display("FAIL reset_result_tcnt got %0d/%0d want 0/0",
                         bus.result, bus.timeout_cnt);
    end
    checks++;
    if (!board_empty()) begin
      errors++; $display("FAIL reset_board got nonempty want empty");
    end
    drive_move(2'd1, 2'd1, a, e);
    checks++;
    if ({a, e} !== 2'b00 || !board_empty()) begin
      errors++; $display("FAIL idle_move_ignored got ack/err %b%b want 00", a, e);
    end
  endtask

  task automatic test_legal_move();
    logic a, e;
    do_start();
    checks++;
    if (bus.cur_player !== 2'd1 || bus.timeout_cnt !== 3'd4) begin
      errors++; $display("FAIL start_state got p%0d t%0d want p1 t4",
                         bus.cur_player, bus.timeout_cnt);
    end
    drive_move(2'd1, 2'd1, a, e);
    checks++;
    if ({a, e} !== 2'b10) begin
      errors++; $display("FAIL legal_ack got ack/err %b%b want 10", a, e);
    end
    checks++;
    if (bus.board[1][1] !== P1 || bus.en_check !== 1'b1) begin
      errors++; $display("FAIL legal_commit got cell %0d en %b want 1 1",
                         bus.board[1][1], bus.en_check);
    end
    step();
    checks++;
    if (bus.en_check !== 1'b0) begin
      errors++; $display("FAIL en_check_one_cycle got %b want 0", bus.en_check);
    end
    step();
    checks++;
    if (bus.cur_player !== 2'd2 || bus.timeout_cnt !== 3'd4) begin
      errors++; $display("FAIL handover got p%0d t%0d want p2 t4",
                         bus.cur_player, bus.timeout_cnt);
    end
  endtask

  task automatic test_illegal_move();
    logic a, e;
    drive_move(2'd1, 2'd1, a, e);
    checks++;
    if ({a, e} !== 2'b01) begin
      errors++; $display("FAIL occupied_err got ack/err %b%b want 01", a, e);
    end
    checks++;
    if (bus.board[1][1] !== P1 || bus.cur_player !== 2'd2 || bus.timeout_cnt !== 3'd3) begin
      errors++; $display("FAIL occupied_hold got cell %0d p%0d t%0d want 1 p2 t3",
                         bus.board[1][1], bus.cur_player, bus.timeout_cnt);
    end
    drive_move(2'd0, 2'd2, a, e);
    checks++;
    if ({a, e} !== 2'b01 || bus.en_check !== 1'b0) begin
      errors++; $display("FAIL row0_err got ack/err/en %b%b%b want 010", a, e, bus.en_check);
    end
  endtask

  task automatic test_row_win();
    logic a, e;
    logic [1:0] rr [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic [1:0] cc [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    do_start();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.winner = 2'd1;
      drive_move(rr[i], cc[i], a, e);
      checks++;
      if ({a, e} !== 2'b10) begin
        errors++; $display("FAIL win_move%0d got ack/err %b%b want 10", i, a, e);
      end
      step();
      step();
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.result !== 2'd1) begin
      errors++; $display("FAIL row_win got over %b res %0d want 1 1",
                         bus.game_over, bus.result);
    end
    bus.winner = 2'd0;
    drive_move(2'd3, 2'd3, a, e);
    checks++;
    if ({a, e} !== 2'b00 || bus.board[3][3] !== EMPTY) begin
      errors++; $display("FAIL over_ignores_move got ack/err %b%b cell %0d want 00 0",
                         a, e, bus.board[3][3]);
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.result !== 2'd1 || bus.board[2][2] !== P2) begin
      errors++; $display("FAIL over_hold got over %b res %0d cell %0d want 1 1 2",
                         bus.game_over, bus.result, bus.board[2][2]);
    end
  endtask

  task automatic test_draw();
    logic a, e;
    bit   ok = 1'b1;
    int   nack = 0;
    do_start();
    bus.winner = 2'd0;
    for (int i = 0; i < 9; i++) begin
      drive_move(draw_r[i], draw_c[i], a, e);
      if (a === 1'b1 && e === 1'b0) nack++;
      step();
      step();
    end
    checks++;
    if (nack != 9) begin
      errors++; $display("FAIL draw_acks got %0d want 9", nack);
    end
    for (int k = 0; k < 9; k++)
      if (bus.board[k / 3 + 1][k % 3 + 1] !== draw_b[k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL draw_board got mismatching cells want 121/122/211");
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.result !== 2'd3) begin
      errors++; $display("FAIL draw_by_count got over %b res %0d want 1 3",
                         bus.game_over, bus.result);
    end
  endtask

  task automatic test_timeout();
    logic a, e;
    do_start();
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (bus.timeout_cnt !== 3'(4 - i) || bus.move_ack !== (i == 3)) begin
          errors++; $display("FAIL timeout_t%0d_c%0d got cnt %0d ack %b want %0d %b",
                             t, i, bus.timeout_cnt, bus.move_ack, 4 - i, (i == 3));
        end
        step();
      end
      checks++;
      if (bus.board[1][t + 1] !== 2'(t + 1) || bus.en_check !== 1'b1) begin
        errors++; $display("FAIL auto_place%0d got cell %0d en %b want %0d 1",
                           t, bus.board[1][t + 1], bus.en_check, t + 1);
      end
      step();
      step();
    end
    step();
    step();
    step();
    checks++;
    if (bus.timeout_cnt !== 3'd1 || bus.cur_player !== 2'd1) begin
      errors++; $display("FAIL expiry_cycle got t%0d p%0d want t1 p1",
                         bus.timeout_cnt, bus.cur_player);
    end
    drive_move(2'd3, 2'd3, a, e);
    checks++;
    if ({a, e} !== 2'b10 || bus.board[3][3] !== P1 || bus.board[1][3] !== EMPTY) begin
      errors++; $display("FAIL move_beats_auto got %b%b cells %0d/%0d want 10 1/0",
                         a, e, bus.board[3][3], bus.board[1][3]);
    end
  endtask

  task automatic test_reset_mid();
    logic a, e;
    do_start();
    drive_move(2'd2, 2'd2, a, e);
    checks++;
    if (bus.en_check !== 1'b1) begin
      errors++; $display("FAIL mid_in_check got en %b want 1", bus.en_check);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (!board_empty() || bus.en_check !== 1'b0 || bus.cur_player !== 2'd0 ||
        bus.timeout_cnt !== '0) begin
      errors++; $display("FAIL reset_mid got en %b p%0d t%0d empty %b want 0 p0 t0 1",
                         bus.en_check, bus.cur_player, bus.timeout_cnt, board_empty());
    end
    step();
    step();
    checks++;
    if (bus.cur_player !== 2'd0 || bus.game_over !== 1'b0 || bus.timeout_cnt !== '0) begin
      errors++; $display("FAIL reset_mid_idle got p%0d over %b t%0d want p0 0 t0",
                         bus.cur_player, bus.game_over, bus.timeout_cnt);
    end
    do_start();
    drive_move(2'd2, 2'd2, a, e);
    step();
    bus.winner = 2'd1;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.winner = 2'd0;
    checks++;
    if (!board_empty() || bus.cur_player !== 2'd1 || bus.game_over !== 1'b0 ||
        bus.result !== 2'd0 || bus.timeout_cnt !== 3'd4) begin
      errors++; $display("FAIL start_in_eval got p%0d over %b res %0d t%0d want p1 0 0 t4",
                         bus.cur_player, bus.game_over, bus.result, bus.timeout_cnt);
    end
    drive_move(2'd1, 2'd1, a, e);
    checks++;
    if ({a, e} !== 2'b10 || bus.board[1][1] !== P1) begin
      errors++; $display("FAIL restart_move got %b%b cell %0d want 10 1",
                         a, e, bus.board[1][1]);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_row   = 2'd0;
    bus.move_col   = 2'd0;
    bus.winner     = 2'd0;
    #1;
    test_reset();
    test_legal_move();
    test_illegal_move();
    test_row_win();
    test_draw();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
